// File: rtl/sonar_scheduler.sv
// sonar_scheduler
// Round-robin ranging controller that shares one echo-timing datapath between
// up to four HC-SR04-style ultrasonic sensors. Each slot fires one trigger,
// times the echo, converts the high time to whole centimetres with a
// prescaler instead of a divider, reports the result, then waits out a quiet
// guard interval so one sensor's ping cannot be heard by the next.
//
// Ports:
//   clock      system clock
//   resetn     asynchronous active-low reset
//   enable     level; 1 = keep scheduling measurements
//   echo       echo lines, one per sensor
//   trig       trigger lines, at most one high at a time
//   distance   last result in cm, saturating at 255 (255 on timeout)
//   sensor_id  sensor index that produced distance
//   valid      one-cycle pulse when distance/sensor_id/timeout update
//   timeout    1 = last result was a timeout
//   busy       1 whenever the scheduler is not idle
//
// Build option: define SONAR_ECHO_SYNC_EN to pass every echo bit through a
// 2-flop synchronizer (adds 2 clocks of latency to edge detection,
// measurement and valid). Left undefined, echo is used as-is and must
// already be synchronous to clock.

module sonar_scheduler #(
  parameter int NUM_SENSORS    = 2,
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_DIVISOR     = 2900,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GUARD_CYCLES   = 500000
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic [7:0]             distance,
  output logic [1:0]             sensor_id,
  output logic                   valid,
  output logic                   timeout,
  output logic                   busy
);

  localparam int TRIG_W  = $clog2(TRIG_CYCLES + 1);
  localparam int PRE_W   = $clog2(CM_DIVISOR + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [TRIG_W-1:0]  TRIG_LAST  = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CM_DIVISOR - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [1:0]         SEL_LAST   = 2'(NUM_SENSORS - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD} state_t;

  state_t                   state_reg;
  logic [1:0]               sel_reg;
  logic [NUM_SENSORS-1:0]   trig_reg;
  logic [TRIG_W-1:0]        trig_cnt_reg;
  logic [PRE_W-1:0]         pre_reg;
  logic [7:0]               cm_reg;
  logic [TO_W-1:0]          to_cnt_reg;
  logic [GUARD_W-1:0]       guard_cnt_reg;
  logic                     echo_prev_reg;
  logic [7:0]               distance_reg;
  logic [1:0]               sensor_id_reg;
  logic                     valid_reg;
  logic                     timeout_reg;
  logic                     busy_reg;

  // Echo conditioning: optional 2-flop synchronizer per bit.
  logic [NUM_SENSORS-1:0] echo_s;
`ifdef SONAR_ECHO_SYNC_EN
  generate
    for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_sync
      logic sync1_reg;
      logic sync2_reg;
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= echo[gi];
          sync2_reg <= sync1_reg;
        end
      end
      assign echo_s[gi] = sync2_reg;
    end
  endgenerate
`else
  assign echo_s = echo;
`endif

  // Zero-pad to the full 2-bit selector range so indexing by sel_reg is
  // always in bounds, whatever NUM_SENSORS is.
  logic [3:0] echo_pad;
  logic       echo_sel;
  logic [1:0] sel_wrap;
  logic       rise;
  logic       to_last;

  assign echo_pad = 4'(echo_s);
  assign echo_sel = echo_pad[sel_reg];
  assign sel_wrap = (sel_reg == SEL_LAST) ? 2'd0 : sel_reg + 2'd1;
  // echo_prev_reg tracks the selected line every clock, so a line that is
  // already high when WAIT_RISE is entered is not seen as an edge.
  assign rise     = echo_sel && !echo_prev_reg;
  assign to_last  = (to_cnt_reg == TO_LAST);

  function automatic logic [NUM_SENSORS-1:0] onehot(input logic [1:0] s);
    logic [3:0] t;
    t = 4'b0001 << s;
    return t[NUM_SENSORS-1:0];
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      sel_reg       <= 2'd0;
      trig_reg      <= '0;
      trig_cnt_reg  <= '0;
      pre_reg       <= '0;
      cm_reg        <= 8'd0;
      to_cnt_reg    <= '0;
      guard_cnt_reg <= '0;
      echo_prev_reg <= 1'b0;
      distance_reg  <= 8'd0;
      sensor_id_reg <= 2'd0;
      valid_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      valid_reg     <= 1'b0;
      echo_prev_reg <= echo_sel;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg    <= TRIG;
            trig_reg     <= onehot(sel_reg);
            trig_cnt_reg <= '0;
            busy_reg     <= 1'b1;
          end
        end
        TRIG: begin
          if (trig_cnt_reg == TRIG_LAST) begin
            trig_reg   <= '0;
            to_cnt_reg <= '0;
            state_reg  <= WAIT_RISE;
          end else begin
            trig_cnt_reg <= trig_cnt_reg + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (to_last) begin
            distance_reg  <= 8'd255;
            sensor_id_reg <= sel_reg;
            timeout_reg   <= 1'b1;
            valid_reg     <= 1'b1;
            guard_cnt_reg <= '0;
            state_reg     <= GUARD;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            if (rise) begin
              pre_reg   <= '0;
              cm_reg    <= 8'd0;
              state_reg <= MEASURE;
            end
          end
        end
        MEASURE: begin
          // Echo fall is tested first so it wins over a same-clock timeout.
          if (!echo_sel) begin
            distance_reg  <= cm_reg;
            sensor_id_reg <= sel_reg;
            timeout_reg   <= 1'b0;
            valid_reg     <= 1'b1;
            guard_cnt_reg <= '0;
            state_reg     <= GUARD;
          end else if (to_last) begin
            distance_reg  <= 8'd255;
            sensor_id_reg <= sel_reg;
            timeout_reg   <= 1'b1;
            valid_reg     <= 1'b1;
            guard_cnt_reg <= '0;
            state_reg     <= GUARD;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
            if (pre_reg == PRE_LAST) begin
              pre_reg <= '0;
              if (cm_reg != 8'd255) cm_reg <= cm_reg + 8'd1;
            end else begin
              pre_reg <= pre_reg + 1'b1;
            end
          end
        end
        GUARD: begin
          if (guard_cnt_reg == GUARD_LAST) begin
            guard_cnt_reg <= '0;
            sel_reg       <= sel_wrap;
            if (enable) begin
              state_reg    <= TRIG;
              trig_reg     <= onehot(sel_wrap);
              trig_cnt_reg <= '0;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            guard_cnt_reg <= guard_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          trig_reg  <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign trig      = trig_reg;
  assign distance  = distance_reg;
  assign sensor_id = sensor_id_reg;
  assign valid     = valid_reg;
  assign timeout   = timeout_reg;
  assign busy      = busy_reg;

endmodule
